// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST sequencer.
//   - 3-bit state encoding (IDLE=0 .. DONE=5), kept as plain constants so
//     legacy code comparing raw state values keeps working.
//   - Per-state Moore output constants and a decode helper.
package bist_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef struct packed {
    logic mode;
    logic init;
    logic running;
    logic finish;
    logic bist_end;
  } bist_outs_t;

  //                                    mode  init  running finish bist_end
  localparam bist_outs_t OUTS_IDLE   = '{1'b0, 1'b0, 1'b0,   1'b0,  1'b0};
  localparam bist_outs_t OUTS_INIT   = '{1'b0, 1'b1, 1'b0,   1'b0,  1'b0};
  localparam bist_outs_t OUTS_RUN    = '{1'b1, 1'b0, 1'b1,   1'b0,  1'b0};
  localparam bist_outs_t OUTS_CHECK  = '{1'b0, 1'b0, 1'b1,   1'b0,  1'b0};
  localparam bist_outs_t OUTS_FINISH = '{1'b0, 1'b0, 1'b0,   1'b1,  1'b0};
  localparam bist_outs_t OUTS_DONE   = '{1'b0, 1'b0, 1'b0,   1'b0,  1'b1};

  function automatic bist_outs_t state_outs(input logic [2:0] st);
    bist_outs_t o;
    o = OUTS_IDLE;
    case (st)
      ST_INIT:   o = OUTS_INIT;
      ST_RUN:    o = OUTS_RUN;
      ST_CHECK:  o = OUTS_CHECK;
      ST_FINISH: o = OUTS_FINISH;
      ST_DONE:   o = OUTS_DONE;
      default:   o = OUTS_IDLE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bist_edge_det.sv
// bist_edge_det: rising-edge detector for the session request.
//   clock : clock, rising edge
//   reset : synchronous, active-high; clears the previous-value register
//   d     : level input
//   rise  : d high while the registered previous value is low
// Because reset clears the previous value, d held high across reset release
// reads as a rising edge on the first non-reset cycle.
module bist_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bist_sequencer.sv
// bist_sequencer: BIST session controller.
//   A session is INIT (1 cycle), then M rounds of RUN (N cycles) + CHECK
//   (1 cycle), then FINISH (1 cycle), then DONE until the next start edge.
// Ports:
//   clock, reset      : clock / synchronous active-high reset
//   bist_start        : session request, acted on only on a 0->1 edge
//   bist_abort        : level, ends a session from INIT/RUN/CHECK
//   fail_in           : DUT mismatch flag, counted only in RUN
//   mode/init/running/finish/bist_end : Moore outputs decoded from state
//   bist_pass, aborted: session verdict, valid while bist_end is high
//   round_cnt         : current round index 0..M-1
//   fail_cnt          : saturating count of failing RUN cycles
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int unsigned N      = 7,
  parameter int unsigned M      = 10,
  parameter int unsigned FAIL_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     bist_start,
  input  logic                     bist_abort,
  input  logic                     fail_in,
  output logic                     mode,
  output logic                     init,
  output logic                     running,
  output logic                     finish,
  output logic                     bist_end,
  output logic                     bist_pass,
  output logic                     aborted,
  output logic [$clog2(M+1)-1:0]   round_cnt,
  output logic [FAIL_W-1:0]        fail_cnt
);

  localparam int unsigned N_W = $clog2(N+1);
  localparam int unsigned M_W = $clog2(M+1);
  localparam logic [N_W-1:0] CYC_LAST = N_W'(N-1);
  localparam logic [M_W-1:0] RND_LAST = M_W'(M-1);

  logic              start_rise;
  logic              abort_ok;
  logic [2:0]        state_q, state_d;
  logic [N_W-1:0]    cyc_q, cyc_d;
  logic [M_W-1:0]    round_q, round_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              aborted_q, aborted_d;
  logic              pass_q, pass_d;
  bist_outs_t        outs;

  bist_edge_det u_start_edge (
    .clock (clock),
    .reset (reset),
    .d     (bist_start),
    .rise  (start_rise)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    round_d   = round_q;
    fail_d    = fail_q;
    aborted_d = aborted_q;
    pass_d    = pass_q;
    abort_ok  = bist_abort &&
                ((state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_CHECK));

    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fail_in && (fail_q != '1)) fail_d = fail_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (round_q == RND_LAST) begin
          state_d = ST_FINISH;
        end else begin
          round_d = round_q + 1'b1;
          cyc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start_rise) state_d = ST_INIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over the normal sequencing; counters freeze where they are
    // (a failing RUN cycle coinciding with abort is still counted).
    if (abort_ok) begin
      state_d = ST_DONE;
      cyc_d   = cyc_q;
      round_d = round_q;
    end

    // Session entry: only IDLE/DONE lead to INIT.
    if ((state_d == ST_INIT) && (state_q != ST_INIT)) begin
      cyc_d     = '0;
      round_d   = '0;
      fail_d    = '0;
      aborted_d = 1'b0;
      pass_d    = 1'b0;
    end

    // Verdict latched once on DONE entry.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      aborted_d = abort_ok;
      pass_d    = !abort_ok && (fail_q == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      round_q   <= '0;
      fail_q    <= '0;
      aborted_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      round_q   <= round_d;
      fail_q    <= fail_d;
      aborted_q <= aborted_d;
      pass_q    <= pass_d;
    end
  end

  assign outs      = state_outs(state_q);
  assign mode      = outs.mode;
  assign init      = outs.init;
  assign running   = outs.running;
  assign finish    = outs.finish;
  assign bist_end  = outs.bist_end;
  assign bist_pass = pass_q;
  assign aborted   = aborted_q;
  assign round_cnt = round_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: self-checking bench for bist_sequencer.
//   Instance A: N=3, M=2, FAIL_W=8 (normal sessions, aborts, reset).
//   Instance B: N=7, M=1, FAIL_W=2 (fail counter saturation).
// Expected behaviour comes from a session-timeline model: the cycle offset
// from the start-detecting edge gives the phase by arithmetic, and a
// saturating tally of random fail_in values seen during RUN phases gives
// the expected fail count.
module tb_bist_sequencer;

  localparam int NA = 3, MA = 2, FWA = 8;
  localparam int NB = 7, MB = 1, FWB = 2;

  localparam int PH_IDLE = 0, PH_INIT = 1, PH_RUN = 2;
  localparam int PH_CHECK = 3, PH_FINISH = 4, PH_DONE = 5;

  logic clock = 1'b0;
  logic reset;

  logic start_a, abort_a, fail_a;
  logic mode_a, init_a, running_a, finish_a, end_a, pass_a, aborted_a;
  logic [$clog2(MA+1)-1:0] round_a;
  logic [FWA-1:0]          fcnt_a;

  logic start_b, abort_b, fail_b;
  logic mode_b, init_b, running_b, finish_b, end_b, pass_b, aborted_b;
  logic [$clog2(MB+1)-1:0] round_b;
  logic [FWB-1:0]          fcnt_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  bist_sequencer #(.N(NA), .M(MA), .FAIL_W(FWA)) dut_a (
    .clock(clock), .reset(reset), .bist_start(start_a), .bist_abort(abort_a),
    .fail_in(fail_a), .mode(mode_a), .init(init_a), .running(running_a),
    .finish(finish_a), .bist_end(end_a), .bist_pass(pass_a), .aborted(aborted_a),
    .round_cnt(round_a), .fail_cnt(fcnt_a)
  );

  bist_sequencer #(.N(NB), .M(MB), .FAIL_W(FWB)) dut_b (
    .clock(clock), .reset(reset), .bist_start(start_b), .bist_abort(abort_b),
    .fail_in(fail_b), .mode(mode_b), .init(init_b), .running(running_b),
    .finish(finish_b), .bist_end(end_b), .bist_pass(pass_b), .aborted(aborted_b),
    .round_cnt(round_b), .fail_cnt(fcnt_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Phase at offset t, where t = 0 is the cycle right after the detecting edge.
  function automatic int phase_of(input int t, input int n, input int m);
    if (t == 0) return PH_INIT;
    if (t <= m*(n+1)) return (((t-1) % (n+1)) < n) ? PH_RUN : PH_CHECK;
    if (t == m*(n+1) + 1) return PH_FINISH;
    return PH_DONE;
  endfunction

  function automatic int round_of(input int t, input int n, input int m);
    if (t == 0) return 0;
    if (t <= m*(n+1)) return (t-1) / (n+1);
    return m - 1;
  endfunction

  task automatic check_all(input int which, input string tag, input int ph, input int rnd,
                           input int fails, input logic pexp, input logic aexp);
    logic o_mode, o_init, o_run, o_fin, o_end, o_pass, o_ab;
    logic [31:0] o_rnd, o_f;
    if (which == 0) begin
      o_mode = mode_a; o_init = init_a; o_run = running_a; o_fin = finish_a;
      o_end = end_a; o_pass = pass_a; o_ab = aborted_a;
      o_rnd = 32'(round_a); o_f = 32'(fcnt_a);
    end else begin
      o_mode = mode_b; o_init = init_b; o_run = running_b; o_fin = finish_b;
      o_end = end_b; o_pass = pass_b; o_ab = aborted_b;
      o_rnd = 32'(round_b); o_f = 32'(fcnt_b);
    end
    chk({tag, " mode"},     32'(o_mode), 32'(ph == PH_RUN));
    chk({tag, " init"},     32'(o_init), 32'(ph == PH_INIT));
    chk({tag, " running"},  32'(o_run),  32'((ph == PH_RUN) || (ph == PH_CHECK)));
    chk({tag, " finish"},   32'(o_fin),  32'(ph == PH_FINISH));
    chk({tag, " bist_end"}, 32'(o_end),  32'(ph == PH_DONE));
    chk({tag, " round"},    o_rnd,       32'(rnd));
    chk({tag, " fail_cnt"}, o_f,         32'(fails));
    if ((ph == PH_DONE) || (ph == PH_IDLE)) begin
      chk({tag, " pass"},    32'(o_pass), 32'(pexp));
      chk({tag, " aborted"}, 32'(o_ab),   32'(aexp));
    end
  endtask

  task automatic set_inputs(input int which, input logic fl, input logic ax);
    if (which == 0) begin
      fail_a = fl; abort_a = ax;
    end else begin
      fail_b = fl; abort_b = ax;
    end
  endtask

  // Caller arranges for the next edge to see a start edge. Runs the whole
  // session to a few cycles into DONE; abort_t < 0 means no abort.
  task automatic session(input int which, input string tag, input int abort_t,
                         input int fail_pct);
    int n, m, fmax, fails, rnd_frz, ph, rnd, total;
    bit ab;
    logic fl, ax;
    n = (which == 0) ? NA : NB;
    m = (which == 0) ? MA : MB;
    fmax = (which == 0) ? ((1 << FWA) - 1) : ((1 << FWB) - 1);
    fails = 0; ab = 0; rnd_frz = 0;
    total = m*(n+1) + 2;
    tick();
    for (int t = 0; t <= total + 2; t++) begin
      ph  = ab ? PH_DONE : phase_of(t, n, m);
      rnd = ab ? rnd_frz : round_of(t, n, m);
      check_all(which, $sformatf("%s t%0d", tag, t), ph, rnd, fails,
                logic'((fails == 0) && !ab), logic'(ab));
      fl = logic'($urandom_range(99) < 32'(fail_pct));
      ax = logic'(t == abort_t);
      set_inputs(which, fl, ax);
      if ((ph == PH_RUN) && fl) fails = (fails < fmax) ? fails + 1 : fmax;
      if (ax && ((ph == PH_INIT) || (ph == PH_RUN) || (ph == PH_CHECK))) begin
        ab = 1'b1;
        rnd_frz = rnd;
      end
      tick();
    end
    set_inputs(which, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b1; abort_a = 1'b0; fail_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; fail_b = 1'b0;
    repeat (3) tick();
    check_all(0, "rst_a", PH_IDLE, 0, 0, 1'b0, 1'b0);
    check_all(1, "rst_b", PH_IDLE, 0, 0, 1'b0, 1'b0);

    // Start held high across reset release, then held through DONE.
    reset = 1'b0;
    session(0, "clean", -1, 0);
    repeat (2) tick();
    check_all(0, "held_start", PH_DONE, MA-1, 0, 1'b1, 1'b0);

    // Drop and re-raise: random fails.
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "rand1", -1, 50);
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "allfail", -1, 100);

    // Abort in the 2nd RUN cycle, then restart clears the verdict.
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "abort_run2", 2, 50);
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "after_abort", -1, 0);

    // Abort during CHECK and during INIT.
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "abort_check", NA + 1, 30);
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "abort_init", 0, 30);

    // Abort during FINISH is ignored.
    start_a = 1'b0; tick();
    start_a = 1'b1;
    session(0, "abort_finish", MA*(NA+1) + 1, 0);

    // Abort together with a start edge in DONE starts a new session.
    start_a = 1'b0; tick();
    start_a = 1'b1; abort_a = 1'b1;
    session(0, "abort_start", -1, 40);

    // Reset mid-RUN, start held high across release.
    start_a = 1'b0; tick();
    start_a = 1'b1; tick(); tick(); tick();
    chk("midrun mode", 32'(mode_a), 32'd1);
    reset = 1'b1; tick();
    check_all(0, "midrun_rst", PH_IDLE, 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    session(0, "post_rst", -1, 30);

    // Abort in IDLE is ignored.
    reset = 1'b1; start_a = 1'b0; tick();
    reset = 1'b0; abort_a = 1'b1; tick(); tick();
    check_all(0, "idle_abort", PH_IDLE, 0, 0, 1'b0, 1'b0);
    abort_a = 1'b0;

    // Saturation on the narrow fail counter.
    start_b = 1'b1;
    session(1, "sat", -1, 100);
    start_b = 1'b0; tick();
    start_b = 1'b1;
    session(1, "sat_rand", -1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
